toy_io_port: RTL and testbench

Synthesizable memory-mapped I/O responder for the TOY CPU bus, replacing the file-based I/O model. It answers CPU `read`/`write` strobes at the I/O address (0xFF) and a status address (0xFE). CPU reads are served from an RX FIFO filled by an external producer over a valid/ready stream. CPU writes go into a TX FIFO drained by an external consumer. It sits beside the memory in the `toy` top level: `addr` is decoded there, and the data mux selects `data_out` for addresses 0xFE/0xFF.

---
 rtl/toy_io_port.sv | 132 +++++++++++++
 tb/tb_toy_io_port.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_io_port.sv
// Memory-mapped I/O responder for the TOY CPU bus: RX FIFO read at IO_ADDR,
// TX FIFO written at IO_ADDR, status/sticky-flag clear at STAT_ADDR.
module toy_io_port #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  IO_ADDR    = 8'hFF,
    parameter logic [7:0]  STAT_ADDR  = 8'hFE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [7:0]            addr,
    input  logic [15:0]           data_in,
    output logic [15:0]           data_out,
    input  logic [15:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DW    = 16;

    logic [DW-1:0] r_rx_mem [DEPTH];
    logic [DW-1:0] r_tx_mem [DEPTH];
    logic [PW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_rx_cnt, r_tx_cnt;
    logic          r_rd_d;
    logic          r_rx_uf, r_tx_ovf;

    logic w_sel_io, w_sel_st, w_rd_now, w_pop_strobe;
    logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic w_rx_push, w_rx_pop, w_rx_uf_set;
    logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf_set, w_flag_clr;
    logic [DW-1:0] w_status;

    assign w_sel_io     = (addr == IO_ADDR);
    assign w_sel_st     = (addr == STAT_ADDR);
    assign w_rd_now     = read && w_sel_io;
    // CPU reads span several cycles; pop once on the trailing edge of the strobe
    assign w_pop_strobe = r_rd_d && !w_rd_now;

    assign w_rx_full    = (r_rx_cnt == CW'(DEPTH));
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_tx_full    = (r_tx_cnt == CW'(DEPTH));
    assign w_tx_empty   = (r_tx_cnt == '0);

    assign w_rx_push    = in_valid && !w_rx_full;
    assign w_rx_pop     = w_pop_strobe && !w_rx_empty;
    assign w_rx_uf_set  = w_pop_strobe && w_rx_empty;

    assign w_tx_wr      = write && w_sel_io;
    assign w_tx_push    = w_tx_wr && !w_tx_full;
    assign w_tx_ovf_set = w_tx_wr && w_tx_full;
    assign w_tx_pop     = out_ready && !w_tx_empty;
    assign w_flag_clr   = write && w_sel_st;

    assign in_ready  = !w_rx_full;
    assign out_valid = !w_tx_empty;
    assign out_data  = r_tx_mem[r_tx_rp];
    assign rx_count  = r_rx_cnt;
    assign tx_count  = r_tx_cnt;

    assign w_status = {r_tx_ovf, r_rx_uf, 6'(r_tx_cnt), 2'b00, 6'(r_rx_cnt)};

    // CPU read data mux
    always_comb begin
        data_out = '0;
        if (w_sel_io && !w_rx_empty) begin
            data_out = r_rx_mem[r_rx_rp];
        end else if (w_sel_st) begin
            data_out = w_status;
        end
    end

    // FIFO storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= in_data;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rd_d   <= 1'b0;
            r_rx_uf  <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            r_rd_d <= w_rd_now;

            if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
            if (w_rx_push && !w_rx_pop) begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_cnt <= r_rx_cnt - CW'(1);
            end

            if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
            if (w_tx_push && !w_tx_pop) begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_cnt <= r_tx_cnt - CW'(1);
            end

            // Setting a sticky flag takes priority over a same-edge clear
            if (w_rx_uf_set) begin
                r_rx_uf <= 1'b1;
            end else if (w_flag_clr) begin
                r_rx_uf <= 1'b0;
            end
            if (w_tx_ovf_set) begin
                r_tx_ovf <= 1'b1;
            end else if (w_flag_clr) begin
                r_tx_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toy_io_port.sv
// Bench for toy_io_port: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized streaming phase.
module tb_toy_io_port;

    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;

    logic        clk, reset_n, read, write;
    logic [7:0]  addr;
    logic [15:0] data_in, data_out, in_data, out_data;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [DL:0] rx_count, tx_count;

    toy_io_port #(.DEPTH_LOG2(DL), .IO_ADDR(8'hFF), .STAT_ADDR(8'hFE)) dut (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(data_out), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: two queues, the trailing-edge read detector and two sticky flags
    logic [15:0] rxq[$];
    logic [15:0] txq[$];
    bit m_prev_rd, m_uf, m_ovf;
    int rx_pushed = 0;
    int tx_pushed = 0;

    always @(posedge clk or negedge reset_n) begin
        bit rd_now, pop_evt, rx_acc, tx_full, drain;
        if (!reset_n) begin
            rxq.delete();
            txq.delete();
            m_prev_rd = 0;
            m_uf      = 0;
            m_ovf     = 0;
        end else begin
            rd_now  = read && (addr == 8'hFF);
            pop_evt = m_prev_rd && !rd_now;
            rx_acc  = in_valid && (rxq.size() < DEPTH);
            tx_full = (txq.size() == DEPTH);
            drain   = out_ready && (txq.size() > 0);
            if (write && addr == 8'hFE) begin
                m_uf  = 0;
                m_ovf = 0;
            end
            if (pop_evt) begin
                if (rxq.size() == 0) m_uf = 1;
                else void'(rxq.pop_front());
            end
            if (rx_acc) begin
                rxq.push_back(in_data);
                rx_pushed++;
            end
            if (drain) void'(txq.pop_front());
            if (write && addr == 8'hFF) begin
                if (tx_full) m_ovf = 1;
                else begin
                    txq.push_back(data_in);
                    tx_pushed++;
                end
            end
            m_prev_rd = rd_now;
        end
    end

    function automatic logic [15:0] exp_status();
        return {m_ovf, m_uf, 6'(txq.size()), 2'b00, 6'(rxq.size())};
    endfunction

    function automatic logic [15:0] exp_dout();
        if (addr == 8'hFF) return (rxq.size() > 0) ? rxq[0] : 16'h0000;
        if (addr == 8'hFE) return exp_status();
        return 16'h0000;
    endfunction

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_in_ready",  16'(in_ready),  16'(rxq.size() < DEPTH));
            chk("m_out_valid", 16'(out_valid), 16'(txq.size() != 0));
            chk("m_rx_count",  16'(rx_count),  16'(rxq.size()));
            chk("m_tx_count",  16'(tx_count),  16'(txq.size()));
            chk("m_data_out",  data_out,       exp_dout());
            if (txq.size() > 0) chk("m_out_data", out_data, txq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_pulse();
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
    endtask

    task automatic ctl_clear();
        addr  = 8'hFE;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rx_fill(input int n, input logic [15:0] base);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = base + 16'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic tx_fill(input int n, input logic [15:0] base);
        addr  = 8'hFF;
        write = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = base + 16'(i);
            tick();
        end
        write = 1'b0;
    endtask

    task automatic drain_all();
        addr      = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && rxq.size() > 0; i++) rd_pulse();
        for (int i = 0; i < 40 && txq.size() > 0; i++) tick();
        chk("drain_rx_empty", 16'(rx_count), 16'h0);
        chk("drain_tx_empty", 16'(tx_count), 16'h0);
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; read = 0; write = 0; addr = 8'h00; data_in = 0;
        in_data = 0; in_valid = 0; out_ready = 0;
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        addr = 8'hFE;
        #1;
        chk("rst_in_ready",  16'(in_ready),  16'h1);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_rx_count",  16'(rx_count),  16'h0);
        chk("rst_status",    data_out,       16'h0000);
        reset_n  = 1'b1;
        check_en = 1;

        // RX fill and trailing-edge pop
        addr = 8'hFF;
        in_valid = 1'b1; in_data = 16'hCAFE; tick();
        in_data = 16'h0010; tick();
        in_valid = 1'b0;
        chk("t1_rx_count", 16'(rx_count), 16'h2);
        chk("t1_head",     data_out,      16'hCAFE);
        read = 1'b1; tick();
        chk("t1_no_pop_while_held", data_out, 16'hCAFE);
        read = 1'b0; tick();
        chk("t1_head_after_pop", data_out,      16'h0010);
        chk("t1_rx_count_pop",   16'(rx_count), 16'h1);
        rd_pulse();

        // RX full, rejected 17th word, ordered reads, underflow
        rx_fill(16, 16'h0100);
        chk("t2_in_ready_full", 16'(in_ready), 16'h0);
        rx_fill(1, 16'hDEAD);
        chk("t2_rx_count_full", 16'(rx_count), 16'h10);
        addr = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            chk("t2_read_word", data_out, (i < 16) ? 16'h0100 + 16'(i) : 16'h0000);
            rd_pulse();
        end
        addr = 8'hFE; #1;
        chk("t2_underflow_status", data_out, 16'h4000);

        // TX overflow with RX full, then control clear
        ctl_clear();
        rx_fill(16, 16'h0300);
        out_ready = 1'b0;
        tx_fill(17, 16'h0200);
        chk("t3_tx_count", 16'(tx_count), 16'h10);
        chk("t3_out_data", out_data,      16'h0200);
        addr = 8'hFE; #1;
        chk("t3_status_ovf", data_out, 16'h9010);
        ctl_clear(); #1;
        chk("t3_status_clr", data_out, 16'h1010);
        drain_all();

        // Decode isolation
        rx_fill(3, 16'h0400);
        tx_fill(2, 16'h0500);
        ctl_clear(); #1;
        chk("t4_status_pre", data_out, 16'h0203);
        addr = 8'h20;
        rd_pulse();
        write = 1'b1; data_in = 16'h1234; tick();
        write = 1'b0; tick();
        addr = 8'hFE;
        rd_pulse();
        chk("t4_status_post", data_out,      16'h0203);
        chk("t4_rx_count",    16'(rx_count), 16'h3);
        chk("t4_tx_count",    16'(tx_count), 16'h2);
        drain_all();

        // Randomized concurrent streaming across pointer wrap
        begin
            int rx0, tx0;
            rx0 = rx_pushed;
            tx0 = tx_pushed;
            addr = 8'hFF;
            for (int c = 0; c < 3000 && (rx_pushed - rx0 < 40 || tx_pushed - tx0 < 40); c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 16'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                write     = ($urandom_range(0, 1) != 0);
                data_in   = 16'($urandom);
                read      = read ? 1'b0 : ($urandom_range(0, 1) != 0);
                tick();
            end
            in_valid = 0; write = 0; read = 0;
            tick();
            chk("t5_rx_streamed", 16'(rx_pushed - rx0 >= 40), 16'h1);
            chk("t5_tx_streamed", 16'(tx_pushed - tx0 >= 40), 16'h1);
        end
        drain_all();
        ctl_clear();

        // Asynchronous reset with both FIFOs half full
        rx_fill(8, 16'h0600);
        tx_fill(8, 16'h0700);
        addr = 8'hFF;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_in_ready",  16'(in_ready),  16'h1);
        chk("t6_out_valid", 16'(out_valid), 16'h0);
        chk("t6_rx_count",  16'(rx_count),  16'h0);
        chk("t6_tx_count",  16'(tx_count),  16'h0);
        chk("t6_data_io",   data_out,       16'h0000);
        addr = 8'hFE; #1;
        chk("t6_data_st",   data_out,       16'h0000);
        @(posedge clk);
        #2 reset_n = 1'b1;
        addr = 8'hFF;
        rx_fill(1, 16'hCAFE);
        tx_fill(1, 16'hBEEF);
        chk("t6_rx_after",  data_out,       16'hCAFE);
        chk("t6_tx_after",  out_data,       16'hBEEF);
        chk("t6_txc_after", 16'(tx_count),  16'h1);
        drain_all();

        tick();
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
